lte_cc_tailbite_sequencer: RTL and testbench
============================================

Name: lte_cc_tailbite_sequencer

Overview:
- Front-end controller for lte_convolutional_encoder (tail-biting, 6-bit state).
- Accepts one code block as a serial bit stream and buffers it.
- Derives the encoder init_word from the block's last 6 bits and pulses load.
- Replays the block into the encoder's din/din_valid/din_last, waits for the encoder's dout_last, then accepts the next block.

Parameters:
- MAX_BLOCK, 2048: maximum block length K in bits; sizes the bit buffer.
- LOAD_GAP, 5: idle cycles between the load pulse and the first din_valid.
- CNT_W, $clog2(MAX_BLOCK+1): width of the length/address counters.

Ports:
- clk  in  1  Rising-edge clock; single clock domain.
- rst_n  in  1  Asynchronous active-low reset.
- in_bit  in  1  Input block bit.
- in_valid  in  1  in_bit is valid.
- in_last  in  1  Marks the final bit of the block; qualified by in_valid.
- in_ready  out  1  Sequencer accepts a bit when in_valid && in_ready.
- init_word  out  6  To encoder. Bit n = block bit K-6+n.
- load  out  1  To encoder. One-cycle pulse; init_word is valid in that cycle.
- din  out  1  To encoder: data bit.
- din_valid  out  1  To encoder.
- din_last  out  1  To encoder. High together with din_valid on bit K-1.
- enc_dout_last  in  1  From encoder dout_last; ends the block.
- busy  out  1  High in every state except IDLE and CAPTURE.
- block_len  out  CNT_W  Length K of the current block. Valid from LOAD until return to IDLE.
- err_short  out  1  One-cycle pulse: block dropped because K<6.
- err_overflow  out  1  One-cycle pulse: MAX_BLOCK bits accepted without in_last.

Behaviour:
- Reset values (async, rst_n=0):
  - State IDLE.
  - in_ready=1; all other outputs 0, including init_word and block_len.
  - Buffer contents are don't-care.
- Reset mid-operation aborts the block immediately. No din_last is emitted.
- All outputs are registered.

States:
- IDLE / CAPTURE, in_ready=1:
  - Each accepted bit is written to buffer[cnt]; cnt increments.
  - Tail shift register updates: tail <= {in_bit, tail[5:1]}.
  - IDLE moves to CAPTURE on the first accepted bit that is not also in_last.
- Accepted bit with in_last, giving K=cnt+1:
  - K<6: err_short pulses next cycle; return to IDLE.
  - K>=6: go to LOAD; latch block_len=K and init_word=tail (including the last bit).
- Accepted bit number MAX_BLOCK without in_last:
  - err_overflow pulses; go to FLUSH.
- FLUSH: in_ready=1; bits are discarded until in_last is accepted, then IDLE. No encoder activity.
- LOAD: in_ready=0; load=1 for exactly one cycle; then GAP.
- GAP: LOAD_GAP cycles with no din_valid; buffer address 0 is prefetched; then STREAM.
- STREAM: K consecutive cycles with din_valid=1 and no bubbles.
  - din = buffer[i] in stream cycle i.
  - din_last=1 only when i=K-1.
  - Then DRAIN.
- DRAIN: in_ready=0; wait for enc_dout_last=1, then go to IDLE.
  - in_ready is high in the following cycle.
  - enc_dout_last seen in any other state is ignored.

Timing:
- in_last accepted at cycle T → load at T+1.
- First din_valid at T+2+LOAD_GAP.
- din_last at T+1+LOAD_GAP+K.
- Accepting a block in the same cycle the previous one completes is impossible: in_ready=0 throughout LOAD..DRAIN.
- Counters never wrap: cnt saturates at MAX_BLOCK in FLUSH.

Test Plan:
- K=40, random bits, encoder attached:
  - load pulses once, with init_word[0]=bit34 and init_word[5]=bit39.
  - 40 contiguous din_valid cycles, starting 6 cycles after load with LOAD_GAP=5.
  - din_last on the 40th; encoder output matches the golden ref file with 0 errors.
- K=6, the minimum: init_word equals the whole block; 6 din cycles; block_len=6.
- K=5: err_short pulses once; no load, no din_valid; in_ready stays 1; a following K=40 block encodes correctly.
- MAX_BLOCK=16, send 20 bits with in_last on bit 20:
  - err_overflow pulses after bit 16; bits 17-20 are discarded; no load.
  - Returns to IDLE; the next block is correct.
- Back-to-back K=64 blocks with in_valid held high:
  - in_ready=0 from LOAD until the cycle after enc_dout_last; no bits are lost or duplicated.
  - Both blocks match the reference.
- Assert rst_n=0 in STREAM at i=20 of K=100:
  - Outputs clear asynchronously, with din_valid=0 immediately.
  - After release, in_ready=1; a new K=40 block encodes correctly.

Source files
------------

// File: rtl/lte_cc_tailbite_sequencer_if.sv
// Serial block-bit stream into the tail-biting sequencer.
interface lte_cc_tailbite_sequencer_if;
  logic in_bit;
  logic in_valid;
  logic in_last;
  logic in_ready;

  // Bit source side.
  modport master (output in_bit, output in_valid, output in_last, input in_ready);
  // Sequencer side.
  modport slave  (input in_bit, input in_valid, input in_last, output in_ready);
endinterface

// File: rtl/lte_cc_tailbite_sequencer.sv
// Front-end controller for a tail-biting LTE convolutional encoder.
// Buffers one code block, loads the encoder state from the block's last six
// bits, then replays the block into the encoder and waits for it to finish.
module lte_cc_tailbite_sequencer #(
  parameter int MAX_BLOCK = 2048,
  parameter int LOAD_GAP  = 5,
  parameter int CNT_W     = $clog2(MAX_BLOCK + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  lte_cc_tailbite_sequencer_if.slave bit_if,
  output logic [5:0]           o_init_word,
  output logic                 o_load,
  output logic                 o_din,
  output logic                 o_din_valid,
  output logic                 o_din_last,
  input  logic                 i_enc_dout_last,
  output logic                 o_busy,
  output logic [CNT_W-1:0]     o_block_len,
  output logic                 o_err_short,
  output logic                 o_err_overflow
);

  localparam int ADDR_W = (MAX_BLOCK > 1) ? $clog2(MAX_BLOCK) : 1;
  localparam int GAP_W  = (LOAD_GAP > 1) ? $clog2(LOAD_GAP) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CAPTURE, S_FLUSH, S_LOAD, S_GAP, S_STREAM, S_DRAIN
  } state_e;

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_idx;
  logic [CNT_W-1:0] r_block_len;
  logic [GAP_W-1:0] r_gap;
  logic [5:0]       r_tail;
  logic [5:0]       r_init_word;
  logic             r_in_ready;
  logic             r_load;
  logic             r_din;
  logic             r_din_valid;
  logic             r_din_last;
  logic             r_busy;
  logic             r_err_short;
  logic             r_err_overflow;
  logic             r_buf [MAX_BLOCK];

  logic             w_accept;
  logic             w_capture;
  logic [CNT_W-1:0] w_k;
  logic [5:0]       w_tail_next;

  assign w_accept    = bit_if.in_valid && r_in_ready;
  assign w_capture   = w_accept && (r_state == S_IDLE || r_state == S_CAPTURE);
  assign w_k         = r_cnt + CNT_W'(1);
  assign w_tail_next = {bit_if.in_bit, r_tail[5:1]};

  // Store each captured bit at its position in the block.
  // NOTE: the bit buffer is plain storage with no reset, so it maps to RAM;
  // its contents are meaningless until a block has been written.
  always_ff @(posedge clk) begin
    if (w_capture) r_buf[r_cnt[ADDR_W-1:0]] <= bit_if.in_bit;
  end

  // Block sequencing FSM; every output is a flop driven from here.
  // NOTE: all state uses non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order within the block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_idx          <= '0;
      r_block_len    <= '0;
      r_gap          <= '0;
      r_tail         <= '0;
      r_init_word    <= '0;
      r_in_ready     <= 1'b1;
      r_load         <= 1'b0;
      r_din          <= 1'b0;
      r_din_valid    <= 1'b0;
      r_din_last     <= 1'b0;
      r_busy         <= 1'b0;
      r_err_short    <= 1'b0;
      r_err_overflow <= 1'b0;
    end else begin
      // NOTE: single-cycle pulses default low here and are raised only in
      // the branch that fires them, so no branch has to remember to clear.
      r_load         <= 1'b0;
      r_err_short    <= 1'b0;
      r_err_overflow <= 1'b0;

      unique case (r_state)
        S_IDLE, S_CAPTURE: begin
          if (w_accept) begin
            r_tail <= w_tail_next;
            if (bit_if.in_last) begin
              r_cnt <= '0;
              if (w_k < CNT_W'(6)) begin
                // Too short to seed a 6-bit tail-biting state: drop it.
                r_err_short <= 1'b1;
                r_state     <= S_IDLE;
              end else begin
                r_init_word <= w_tail_next;
                r_block_len <= w_k;
                r_load      <= 1'b1;
                r_in_ready  <= 1'b0;
                r_busy      <= 1'b1;
                r_state     <= S_LOAD;
              end
            end else if (w_k == CNT_W'(MAX_BLOCK)) begin
              // Buffer full with no end in sight; discard the remainder.
              r_cnt          <= w_k;
              r_err_overflow <= 1'b1;
              r_busy         <= 1'b1;
              r_state        <= S_FLUSH;
            end else begin
              r_cnt   <= w_k;
              r_state <= S_CAPTURE;
            end
          end
        end

        S_FLUSH: begin
          if (w_accept && bit_if.in_last) begin
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end

        S_LOAD: begin
          r_gap   <= '0;
          r_idx   <= '0;
          r_state <= S_GAP;
        end

        S_GAP: begin
          if (r_gap == GAP_W'(LOAD_GAP - 1)) begin
            // Bit 0 is fetched during the last gap cycle so streaming
            // starts without a bubble.
            r_din       <= r_buf[0];
            r_din_valid <= 1'b1;
            r_din_last  <= (r_block_len == CNT_W'(1));
            r_idx       <= CNT_W'(1);
            r_state     <= S_STREAM;
          end else begin
            r_gap <= r_gap + GAP_W'(1);
          end
        end

        S_STREAM: begin
          if (r_idx == r_block_len) begin
            r_din       <= 1'b0;
            r_din_valid <= 1'b0;
            r_din_last  <= 1'b0;
            r_state     <= S_DRAIN;
          end else begin
            r_din      <= r_buf[r_idx[ADDR_W-1:0]];
            r_din_last <= (r_idx == r_block_len - CNT_W'(1));
            r_idx      <= r_idx + CNT_W'(1);
          end
        end

        S_DRAIN: begin
          if (i_enc_dout_last) begin
            r_block_len <= '0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bit_if.in_ready = r_in_ready;
  assign o_init_word     = r_init_word;
  assign o_load          = r_load;
  assign o_din           = r_din;
  assign o_din_valid     = r_din_valid;
  assign o_din_last      = r_din_last;
  assign o_busy          = r_busy;
  assign o_block_len     = r_block_len;
  assign o_err_short     = r_err_short;
  assign o_err_overflow  = r_err_overflow;

endmodule

// File: tb/tb_lte_cc_tailbite_sequencer.sv
// Scoreboard bench: the driver pushes the events each block should cause,
// a negedge monitor pops and compares them as the sequencer produces them.
module tb_lte_cc_tailbite_sequencer;
  localparam int MAX_BLOCK = 100;
  localparam int LOAD_GAP  = 5;
  localparam int CNT_W     = $clog2(MAX_BLOCK + 1);

  typedef enum logic [1:0] {EV_LOAD, EV_DIN, EV_SHORT, EV_OVF} ev_e;
  typedef struct {
    ev_e        kind;
    logic [5:0] init;
    int         len;
    int         idx;
    logic       bit_v;
    logic       last;
  } ev_t;

  logic             clk;
  logic             rst_n;
  logic [5:0]       init_word;
  logic             load, din, din_valid, din_last, enc_dout_last, busy;
  logic [CNT_W-1:0] block_len;
  logic             err_short, err_overflow;

  lte_cc_tailbite_sequencer_if bit_if ();

  lte_cc_tailbite_sequencer #(.MAX_BLOCK(MAX_BLOCK), .LOAD_GAP(LOAD_GAP)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bit_if         (bit_if),
    .o_init_word    (init_word),
    .o_load         (load),
    .o_din          (din),
    .o_din_valid    (din_valid),
    .o_din_last     (din_last),
    .i_enc_dout_last(enc_dout_last),
    .o_busy         (busy),
    .o_block_len    (block_len),
    .o_err_short    (err_short),
    .o_err_overflow (err_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int  n_pass   = 0;
  int  n_checks = 0;
  ev_t sb [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic pop_ev(input ev_e k, output bit ok, output ev_t e);
    ok = 1'b0;
    check({"event_pending_", k.name()}, (sb.size() > 0), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({"event_kind_", k.name()}, e.kind, k);
      ok = (e.kind == k);
    end
  endtask

  // Encoder stand-in: answers din_last with dout_last 1..4 cycles later and
  // emits stray dout_last pulses at other times, which must be ignored.
  bit stub_drain;
  int stub_dly;
  initial begin
    enc_dout_last = 1'b0;
    stub_drain    = 1'b0;
    stub_dly      = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        enc_dout_last = 1'b0;
        stub_drain    = 1'b0;
      end else if (stub_drain) begin
        stub_dly--;
        enc_dout_last = (stub_dly == 0);
        if (stub_dly == 0) stub_drain = 1'b0;
      end else if (din_valid && din_last) begin
        stub_drain    = 1'b1;
        stub_dly      = $urandom_range(1, 4);
        enc_dout_last = 1'b0;
      end else begin
        enc_dout_last = ($urandom_range(0, 19) == 0);
      end
    end
  end

  // Monitor: compares outputs against queued expectations and tracks when
  // the sequencer must refuse input (load through the encoder's dout_last).
  bit  blocked      = 1'b0;
  bit  seen_last    = 1'b0;
  int  load_cyc     = 0;
  int  last_acc_cyc = 0;
  int  ovf_cyc      = 0;
  int  acc_n        = 0;
  ev_t m_e;
  bit  m_ok;

  always @(negedge clk) begin
    if (rst_n) begin
      if (load) begin
        pop_ev(EV_LOAD, m_ok, m_e);
        if (m_ok) begin
          check("load_init_word", init_word, m_e.init);
          check("load_block_len", block_len, m_e.len);
          check("load_timing", cyc, last_acc_cyc + 1);
          check("load_busy", busy, 1);
        end
        load_cyc  = cyc;
        blocked   = 1'b1;
        seen_last = 1'b0;
      end
      if (din_valid) begin
        pop_ev(EV_DIN, m_ok, m_e);
        if (m_ok) begin
          check("din_bit", din, m_e.bit_v);
          check("din_last", din_last, m_e.last);
          check("din_timing", cyc, load_cyc + LOAD_GAP + 1 + m_e.idx);
        end
      end
      if (err_short) begin
        pop_ev(EV_SHORT, m_ok, m_e);
        check("err_short_timing", cyc, last_acc_cyc + 1);
        check("err_short_busy", busy, 0);
      end
      if (err_overflow) begin
        pop_ev(EV_OVF, m_ok, m_e);
        check("err_overflow_timing", cyc, ovf_cyc + 1);
        check("err_overflow_busy", busy, 1);
      end
      check("in_ready", bit_if.in_ready, !blocked);
      if (din_valid && din_last) seen_last = 1'b1;
      if (enc_dout_last && seen_last) begin
        blocked   = 1'b0;
        seen_last = 1'b0;
      end
      if (bit_if.in_valid && bit_if.in_ready) begin
        if (bit_if.in_last) begin
          last_acc_cyc = cyc;
          acc_n        = 0;
        end else begin
          acc_n++;
          if (acc_n == MAX_BLOCK) ovf_cyc = cyc;
        end
      end
    end
  end

  // Queue the expected events for a block of random bits, then drive it.
  task automatic send_block(input int len, input int gap_pct, input bit hold);
    logic       bits [$];
    logic [5:0] iw;
    bit         acc;
    int         guard;
    for (int i = 0; i < len; i++) bits.push_back(1'($urandom_range(0, 1)));
    if (len < 6) begin
      sb.push_back('{EV_SHORT, 6'd0, len, 0, 1'b0, 1'b0});
    end else if (len > MAX_BLOCK) begin
      sb.push_back('{EV_OVF, 6'd0, len, 0, 1'b0, 1'b0});
    end else begin
      for (int n = 0; n < 6; n++) iw[n] = bits[len - 6 + n];
      sb.push_back('{EV_LOAD, iw, len, 0, 1'b0, 1'b0});
      for (int i = 0; i < len; i++)
        sb.push_back('{EV_DIN, 6'd0, len, i, bits[i], (i == len - 1)});
    end
    for (int i = 0; i < len; i++) begin
      if ($urandom_range(0, 99) < gap_pct) begin
        bit_if.in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      bit_if.in_valid = 1'b1;
      bit_if.in_bit   = bits[i];
      bit_if.in_last  = (i == len - 1);
      guard = 0;
      do begin
        @(negedge clk);
        acc = bit_if.in_ready;
        @(posedge clk);
        #1;
        guard++;
      end while (!acc && guard < 2000);
      check("bit_accepted", acc, 1);
    end
    if (!hold) begin
      bit_if.in_valid = 1'b0;
      bit_if.in_last  = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int g = 0;
    while ((sb.size() != 0 || blocked) && g < 5000) begin
      @(posedge clk);
      g++;
    end
    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, bit_if.in_ready, 1);
    check({tag, "_load"}, load, 0);
    check({tag, "_din_valid"}, din_valid, 0);
    check({tag, "_din_last"}, din_last, 0);
    check({tag, "_din"}, din, 0);
    check({tag, "_init_word"}, init_word, 0);
    check({tag, "_block_len"}, block_len, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_err_short"}, err_short, 0);
    check({tag, "_err_overflow"}, err_overflow, 0);
  endtask

  // Abort a K=100 block with reset while stream bit 20 is on din.
  task automatic reset_mid_stream();
    int beats = 0;
    int g     = 0;
    send_block(100, 0, 1'b0);
    while (beats < 20 && g < 1000) begin
      @(negedge clk);
      if (din_valid) beats++;
      g++;
    end
    check("reset_reached_beat20", beats, 20);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    sb.delete();
    blocked   = 1'b0;
    seen_last = 1'b0;
    acc_n     = 0;
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_in_ready", bit_if.in_ready, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit_if.in_bit   = 1'b0;
    bit_if.in_valid = 1'b0;
    bit_if.in_last  = 1'b0;
    rst_n           = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check_reset_outputs("reset");
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    send_block(40, 20, 1'b0);  wait_idle();
    send_block(6, 0, 1'b0);    wait_idle();
    send_block(5, 0, 1'b0);
    send_block(40, 0, 1'b0);   wait_idle();
    send_block(105, 10, 1'b0);
    send_block(40, 0, 1'b0);   wait_idle();
    send_block(64, 0, 1'b1);
    send_block(64, 0, 1'b0);   wait_idle();
    send_block(MAX_BLOCK, 0, 1'b0); wait_idle();
    for (int j = 0; j < 8; j++)
      send_block($urandom_range(1, 110), 25, (j < 7) && ($urandom_range(0, 1) == 1));
    wait_idle();
    reset_mid_stream();
    send_block(40, 0, 1'b0);   wait_idle();

    check("final_busy", busy, 0);
    check("final_in_ready", bit_if.in_ready, 1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
